// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the debug-link UART receive path:
//   - rx_state_e : receiver FSM state encodings
//   - DEF_*      : default frame / baud / FIFO constants (100 MHz, 19200 baud)
//   - CMD_*      : debug command byte values understood by the debug FSM parser
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int DEF_DBIT     = 8;
    localparam int DEF_SB_TICK  = 16;
    localparam int DEF_DVSR     = 326;   // 100 MHz / (19200 * 16)
    localparam int DEF_DVSR_BIT = 9;
    localparam int DEF_FIFO_W   = 5;

    // Debug command bytes seen by the command/program-load parser.
    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_PING = 8'h01;
    localparam logic [7:0] CMD_HALT = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'h03;
    localparam logic [7:0] CMD_LOAD = 8'h04;

endpackage

// File: rtl/uart_rx_path_fifo_fwft.sv
// -----------------------------------------------------------------------------
// fifo_fwft
// First-word-fall-through byte FIFO, 2^FIFO_W entries.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   push, w_data   : write w_data at the tail (caller guarantees room or a
//                    same-cycle pop)
//   pop            : drop the head (caller guarantees not empty)
//   r_data         : head entry, combinational; 0 while empty
//   empty, full    : occupancy flags
//   count          : occupancy 0..2^FIFO_W
// -----------------------------------------------------------------------------
module fifo_fwft #(
    parameter int DBIT   = 8,
    parameter int FIFO_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DBIT-1:0]   w_data,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [FIFO_W:0]   count
);

    localparam int DEPTH = 1 << FIFO_W;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;

    // Storage carries no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_W'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_W+1)'(1);
                2'b01:   count <= count - (FIFO_W+1)'(1);
                default: count <= count;   // idle, or push+pop cancel
            endcase
        end
    end

    assign empty  = (count == '0);
    assign full   = (count == (FIFO_W+1)'(DEPTH));
    // Masked while empty so the head reads 0 out of reset.
    assign r_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_path.sv
// -----------------------------------------------------------------------------
// uart_rx_path
// Receive half of the debug link: baud tick generator, 2-FF synchronizer,
// 16x-oversampling 8N1 receiver and FWFT byte FIFO.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_rx           : asynchronous serial line, idle high
//   i_rd_uart      : pop request (ignored when empty)
//   o_r_data       : FIFO head, valid while o_rx_empty=0
//   o_rx_empty/full/count : FIFO status
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_overrun      : sticky, byte dropped because FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_path
    import uart_pkg::*;
#(
    parameter int DBIT     = DEF_DBIT,
    parameter int SB_TICK  = DEF_SB_TICK,
    parameter int DVSR     = DEF_DVSR,
    parameter int DVSR_BIT = DEF_DVSR_BIT,
    parameter int FIFO_W   = DEF_FIFO_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx,
    input  logic              i_rd_uart,
    output logic [DBIT-1:0]   o_r_data,
    output logic              o_rx_empty,
    output logic              o_rx_full,
    output logic [FIFO_W:0]   o_rx_count,
    output logic              o_frame_err,
    output logic              o_overrun
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    // ---------------- baud tick ----------------
    logic [DVSR_BIT-1:0] baud_cnt;
    logic                tick;

    assign tick = (baud_cnt == DVSR_BIT'(DVSR - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset || tick) baud_cnt <= '0;
        else                 baud_cnt <= baud_cnt + DVSR_BIT'(1);
    end

    // ---------------- input path ----------------
    logic       rx_meta, rx_s, rx_prev;
    logic [1:0] sync_vld;
    logic       armed;
    logic       fall;

    // The synchronizer resets to 1, so a line held low across reset would
    // look like a falling edge once the real level shifts in. sync_vld marks
    // when rx_s carries the real line; 'armed' then waits for a genuine high
    // level before any falling edge may open a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            sync_vld <= '0;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= i_rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_s) armed <= 1'b1;
        end
    end

    assign fall = armed & rx_prev & ~rx_s;

    // ---------------- receiver FSM ----------------
    rx_state_e       state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            done;
    logic            ferr_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= RX_IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            o_frame_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            o_frame_err <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    s_d     = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        // Mid start bit: still low means a real frame.
                        if (!rx_s) begin
                            state_d = RX_DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};   // LSB first
                        if (n_q == NW'(DBIT - 1)) state_d = RX_STOP;
                        else                      n_d = n_q + NW'(1);
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d = RX_IDLE;
                        if (rx_s) done   = 1'b1;
                        else      ferr_d = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // ---------------- FIFO ----------------
    logic pop, push;

    assign pop  = i_rd_uart & ~o_rx_empty;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push = done & (~o_rx_full | pop);

    always_ff @(posedge i_clk) begin
        if (i_reset)                       o_overrun <= 1'b0;
        else if (done && o_rx_full && !pop) o_overrun <= 1'b1;
    end

    fifo_fwft #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) u_fifo (
        .clk    (i_clk),
        .reset  (i_reset),
        .push   (push),
        .pop    (pop),
        .w_data (b_q),
        .r_data (o_r_data),
        .empty  (o_rx_empty),
        .full   (o_rx_full),
        .count  (o_rx_count)
    );

endmodule
